branch_pc_unit: RTL
===================

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter PC_W, 10, program-counter width in bits.
REQ-002 Parameter START_PC, 10'd0, PC value loaded on reset and on every Start.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  begin program execution from START_PC.
REQ-006 Halt  input  1  decoded halt instruction in the current cycle.
REQ-007 Stall  input  1  hold PC this cycle, e.g. for a multi-cycle LOAD/STORE.
REQ-008 Flag_we  input  1  capture ALU flags at the next edge.
REQ-009 ZERO, BEVEN, PARITY, EQUAL  input  1 each  flag outputs of the ALU stage.
REQ-010 Branch_en  input  1  current instruction is a conditional branch.
REQ-011 Branch_cond  input  2  flag select: 00 ZERO, 01 BEVEN, 10 PARITY, 11 EQUAL.
REQ-012 Branch_inv  input  1  branch when the selected flag is 0 instead of 1.
REQ-013 Branch_abs  input  1  1 = absolute target, 0 = PC-relative offset.
REQ-014 Target  input  PC_W  absolute target from the branch LUT.
REQ-015 Offset  input  8  signed two's-complement relative offset.
REQ-016 PC  output  PC_W  current instruction address.
REQ-017 Flags  output  4  registered {ZERO, BEVEN, PARITY, EQUAL}, MSB first.
REQ-018 Fetch_valid  output  1  PC is a live instruction address (state RUN).
REQ-019 Taken  output  1  registered; high for one cycle after a branch is taken.
REQ-020 Done  output  1  program halted; high throughout HALT.

Function
REQ-021 States SHALL be IDLE, RUN and HALT.
REQ-022 Transitions: IDLE->RUN on Start; RUN->HALT on Halt; HALT->RUN on Start.
REQ-023 On entering RUN, PC SHALL load START_PC at the same edge.
REQ-024 In IDLE and HALT, PC, Flags and Taken SHALL hold; Halt, Stall, Flag_we and Branch_en are ignored.
REQ-025 Start in RUN SHALL be ignored.
REQ-026 In RUN with Stall=0, Halt=0 and no branch taken, PC SHALL become PC+1 at the next edge, modulo 2^PC_W (1023->0).
REQ-027 Branch taken = Branch_en & (selected registered flag ^ Branch_inv); the decision uses Flags before any same-cycle Flag_we update.
REQ-028 On a taken branch:
- Branch_abs=1: PC <= Target.
- Branch_abs=0: PC <= PC + sign-extended Offset, modulo 2^PC_W.
- Taken <= 1 for exactly one cycle.
REQ-029 Stall=1 in RUN SHALL hold PC and suppress branch and Taken; Flag_we is still honoured.
REQ-030 Flag_we=1 in RUN SHALL load Flags from the ALU flag inputs, independent of branch and Stall.
REQ-031 Halt in RUN SHALL take priority over Stall and branch; PC holds and Flag_we is still honoured.
REQ-032 Fetch_valid SHALL equal (state==RUN) and Done SHALL equal (state==HALT), both decoded from registered state.
REQ-033 Branch latency SHALL be 1 cycle: the target appears on PC at the edge after the branch cycle.

Reset
REQ-034 Reset_n low SHALL immediately force state IDLE, PC=START_PC, Flags=0, Taken=0, Fetch_valid=0, Done=0.
REQ-035 Reset mid-RUN SHALL abandon execution; a new Start is required after release.

Structure
REQ-036 The state enum, Branch_cond encodings and the START_PC default SHALL live in the shared definitions package.
REQ-037 One sub-module, branch_cond_eval, SHALL select and invert the flag and produce the taken signal combinationally.

Verification
REQ-038 Reset, then Start pulse, 5 idle cycles -> PC sequence 0,1,2,3,4,5; Fetch_valid=1.
REQ-039 Flag_we with EQUAL=1, next cycle Branch_en, cond=11, abs, Target=200 -> PC=200 next edge; Taken pulses 1 cycle.
REQ-040 PC=3, Flags ZERO=0, Branch_en, cond=00, inv=1, rel, Offset=-3 -> PC=0; repeat with PC=0, Offset=-1 -> PC=1023.
REQ-041 Stall and a taken branch in the same cycle at PC=10 -> PC stays 10, Taken=0; Stall drops, branch repeated -> branch taken.
REQ-042 Halt with a taken branch at PC=7 -> PC=7, Done=1, Fetch_valid=0; Start -> PC=0, Done=0.
REQ-043 Reset_n asserted asynchronously mid-RUN at PC=50 -> PC=0 and IDLE immediately; PC frozen until Start.

Source files
------------

// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch/PC unit: sequencer states, branch
// condition encodings and default geometry of the program counter.
package branch_pc_unit_pkg;

    // Default program-counter width and start address.
    localparam int          DEFAULT_PC_W     = 10;
    localparam int unsigned DEFAULT_START_PC = 0;

    // Width of the signed relative branch offset.
    localparam int OFFSET_W = 8;

    // Execution sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Branch condition select encodings (index into the flag register).
    typedef enum logic [1:0] {
        COND_ZERO   = 2'b00,
        COND_BEVEN  = 2'b01,
        COND_PARITY = 2'b10,
        COND_EQUAL  = 2'b11
    } branch_cond_t;

    // Bit positions of each flag inside the packed {ZERO,BEVEN,PARITY,EQUAL} word.
    localparam int FLAG_ZERO   = 3;
    localparam int FLAG_BEVEN  = 2;
    localparam int FLAG_PARITY = 1;
    localparam int FLAG_EQUAL  = 0;

endpackage

// File: rtl/branch_pc_unit_cond_eval.sv
// Combinational branch decision: pick one registered flag by the condition
// select, optionally invert it, and gate with the branch enable.
module branch_cond_eval
    import branch_pc_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  logic       branch_en,
    input  logic [1:0] branch_cond,
    input  logic       branch_inv,
    output logic       taken
);

    logic selected;

    // Select the flag named by the condition code and form the decision.
    always_comb begin
        selected = 1'b0;
        case (branch_cond_t'(branch_cond))
            COND_ZERO:   selected = flags[FLAG_ZERO];
            COND_BEVEN:  selected = flags[FLAG_BEVEN];
            COND_PARITY: selected = flags[FLAG_PARITY];
            COND_EQUAL:  selected = flags[FLAG_EQUAL];
            default:     selected = 1'b0;
        endcase
        taken = branch_en & (selected ^ branch_inv);
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter sequencer with conditional branching on registered ALU
// flags. A three-state sequencer (IDLE/RUN/HALT) gates all PC and flag
// updates; branches resolve in one cycle using the flags as they stood at
// the start of the cycle. dbg_state mirrors the registered sequencer state.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    // PC_W must be wider than the 8-bit relative offset.
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] START_PC = PC_W'(DEFAULT_START_PC)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            halt,
    input  logic            stall,
    input  logic            flag_we,
    input  logic            zero,
    input  logic            beven,
    input  logic            parity,
    input  logic            equal,
    input  logic            branch_en,
    input  logic [1:0]      branch_cond,
    input  logic            branch_inv,
    input  logic            branch_abs,
    input  logic [PC_W-1:0] target,
    input  logic [7:0]      offset,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      flags,
    output logic            fetch_valid,
    output logic            taken,
    output logic            done,
    output logic [1:0]      dbg_state
);

    localparam int EXT_W = PC_W - OFFSET_W;

    state_t          state;
    logic            branch_taken;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_branch;
    logic [3:0]      alu_flags;

    assign alu_flags = {zero, beven, parity, equal};
    assign dbg_state = state;

    branch_cond_eval u_cond_eval (
        .flags       (flags),
        .branch_en   (branch_en),
        .branch_cond (branch_cond),
        .branch_inv  (branch_inv),
        .taken       (branch_taken)
    );

    // Candidate next addresses: sequential and branch target (both wrap mod 2^PC_W).
    always_comb begin
        pc_seq    = pc + PC_W'(1);
        pc_branch = pc + {{EXT_W{offset[7]}}, offset};
        if (branch_abs) begin
            pc_branch = target;
        end
    end

    // Sequencer with registered PC, flags and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc          <= START_PC;
            flags       <= 4'b0000;
            taken       <= 1'b0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    // Everything holds until a new Start restarts the program.
                    if (start) begin
                        state       <= ST_RUN;
                        pc          <= START_PC;
                        fetch_valid <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Flag capture is independent of halt, stall and branch.
                    if (flag_we) begin
                        flags <= alu_flags;
                    end
                    if (halt) begin
                        state       <= ST_HALT;
                        taken       <= 1'b0;
                        fetch_valid <= 1'b0;
                        done        <= 1'b1;
                    end else if (stall) begin
                        taken <= 1'b0;
                    end else if (branch_taken) begin
                        pc    <= pc_branch;
                        taken <= 1'b1;
                    end else begin
                        pc    <= pc_seq;
                        taken <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    pc          <= START_PC;
                    taken       <= 1'b0;
                    fetch_valid <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule
